// File: rtl/fir_accum_seq_pkg.sv
// Shared types and constants for the FIR accumulation sequencer.
package fir_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Datapath width and signed clamp limits.
    localparam int          DATA_W  = 16;
    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/fir_accum_seq_if.sv
// Product stream in, accumulated result out, plus frame control.
interface fir_accum_seq_if;
    import fir_pkg::*;

    logic              start;
    logic              prod_valid;
    logic [DATA_W-1:0] prod_data;
    logic              prod_ready;
    logic              busy;
    logic              y_valid;
    logic              y_ready;
    logic [DATA_W-1:0] y_data;
    logic              y_ovf;

    // Producer/consumer side (the surrounding datapath).
    modport master (
        output start, prod_valid, prod_data, y_ready,
        input  prod_ready, busy, y_valid, y_data, y_ovf
    );

    // Sequencer side.
    modport slave (
        input  start, prod_valid, prod_data, y_ready,
        output prod_ready, busy, y_valid, y_data, y_ovf
    );

endinterface

// File: rtl/fir_accum_seq_rca.sv
// 16-bit ripple-carry adder built from explicit full-adder cells.
module rca
    import fir_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              ci,
    output logic [DATA_W-1:0] s,
    output logic              co
);

    // Carry ripples LSB to MSB through one full adder per bit.
    always_comb begin
        logic carry;
        s     = '0;
        carry = ci;
        for (int i = 0; i < DATA_W; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/fir_accum_seq.sv
// Accumulates NTAPS signed products through one shared ripple adder and
// emits one 16-bit sum per frame with a sticky overflow flag.
module fir_accum_seq
    import fir_pkg::*;
#(
    parameter int NTAPS    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    fir_accum_seq_if.slave bus
);

    localparam int               CNT_W = ($clog2(NTAPS) < 1) ? 1 : $clog2(NTAPS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NTAPS - 1);

    state_t                   state;
    logic signed [DATA_W-1:0] acc;
    logic        [CNT_W-1:0]  cnt;
    logic                     ovf;
    logic        [DATA_W-1:0] sum;
    logic                     ov;
    logic signed [DATA_W-1:0] acc_next;
    logic                     take;

    // Single shared adder; carry-out is not needed for signed overflow.
    rca rca_inst (
        .a  (acc),
        .b  (bus.prod_data),
        .ci (1'b0),
        .s  (sum),
        .co ()
    );

    // Signed overflow detect and optional clamp after the adder.
    always_comb begin
        ov       = (acc[DATA_W-1] == bus.prod_data[DATA_W-1]) &&
                   (sum[DATA_W-1] != acc[DATA_W-1]);
        acc_next = sum;
        if (SATURATE && ov) begin
            acc_next = acc[DATA_W-1] ? SAT_MIN : SAT_MAX;
        end
        take     = bus.prod_valid & bus.prod_ready;
    end

    // Frame FSM with all outputs registered as state decodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            acc            <= '0;
            cnt            <= '0;
            ovf            <= 1'b0;
            bus.prod_ready <= 1'b0;
            bus.busy       <= 1'b0;
            bus.y_valid    <= 1'b0;
            bus.y_data     <= '0;
            bus.y_ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state          <= ACC;
                        acc            <= '0;
                        cnt            <= '0;
                        ovf            <= 1'b0;
                        bus.prod_ready <= 1'b1;
                        bus.busy       <= 1'b1;
                    end
                end
                ACC: begin
                    if (take) begin
                        acc <= acc_next;
                        ovf <= ovf | ov;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state          <= OUT;
                            cnt            <= '0;
                            bus.prod_ready <= 1'b0;
                            bus.y_valid    <= 1'b1;
                            bus.y_data     <= acc_next;
                            bus.y_ovf      <= ovf | ov;
                        end
                    end
                end
                OUT: begin
                    if (bus.y_ready) begin
                        state       <= IDLE;
                        bus.busy    <= 1'b0;
                        bus.y_valid <= 1'b0;
                        bus.y_data  <= '0;
                        bus.y_ovf   <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    bus.prod_ready <= 1'b0;
                    bus.busy       <= 1'b0;
                    bus.y_valid    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_accum_seq.sv
// Directed bench: three sequencer configurations sharing one clock/reset.
module tb_fir_accum_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    fir_accum_seq_if ifa ();
    fir_accum_seq_if ifw ();
    fir_accum_seq_if ifs ();

    fir_accum_seq #(.NTAPS(4), .SATURATE(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    fir_accum_seq #(.NTAPS(2), .SATURATE(1'b0)) dut_w (.clk(clk), .rst(rst), .bus(ifw.slave));
    fir_accum_seq #(.NTAPS(4), .SATURATE(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(ifs.slave));

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        chk("rst_prod_ready", {15'd0, ifa.prod_ready}, 16'd0);
        chk("rst_busy",       {15'd0, ifa.busy},       16'd0);
        chk("rst_y_valid",    {15'd0, ifa.y_valid},    16'd0);
        chk("rst_y_data",     ifa.y_data,              16'd0);
        chk("rst_y_ovf",      {15'd0, ifa.y_ovf},      16'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", {15'd0, ifa.busy}, 16'd0);
    endtask

    task automatic test_basic_sum();
        ifa.y_ready = 1'b1;
        ifa.start   = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        chk("basic_prod_ready", {15'd0, ifa.prod_ready}, 16'd1);
        chk("basic_busy",       {15'd0, ifa.busy},       16'd1);
        for (int i = 0; i < 4; i++) begin
            ifa.prod_valid = 1'b1;
            ifa.prod_data  = 16'(i + 1);
            @(negedge clk);
            if (i < 3) chk("basic_no_early_valid", {15'd0, ifa.y_valid}, 16'd0);
        end
        ifa.prod_valid = 1'b0;
        chk("basic_y_valid",    {15'd0, ifa.y_valid},    16'd1);
        chk("basic_y_data",     ifa.y_data,              16'd10);
        chk("basic_y_ovf",      {15'd0, ifa.y_ovf},      16'd0);
        chk("basic_out_ready",  {15'd0, ifa.prod_ready}, 16'd0);
        @(negedge clk);
        chk("basic_idle_valid", {15'd0, ifa.y_valid},    16'd0);
        chk("basic_idle_busy",  {15'd0, ifa.busy},       16'd0);
    endtask

    task automatic test_signed_stalls();
        logic [15:0] v [4];
        v[0] = 16'hFFFF; v[1] = 16'h0005; v[2] = 16'hFFFE; v[3] = 16'h0001;
        ifa.y_ready = 1'b1;
        ifa.start   = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ifa.prod_valid = 1'b1;
            ifa.prod_data  = v[i];
            @(negedge clk);
            ifa.prod_valid = 1'b0;
            ifa.prod_data  = 16'h7777;
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    @(negedge clk);
                    chk("stall_prod_ready", {15'd0, ifa.prod_ready}, 16'd1);
                    chk("stall_no_valid",   {15'd0, ifa.y_valid},    16'd0);
                end
            end
        end
        chk("stall_y_valid", {15'd0, ifa.y_valid}, 16'd1);
        chk("stall_y_data",  ifa.y_data,           16'd3);
        chk("stall_y_ovf",   {15'd0, ifa.y_ovf},   16'd0);
        @(negedge clk);
        chk("stall_idle", {15'd0, ifa.busy}, 16'd0);
    endtask

    task automatic test_wrap();
        ifw.y_ready = 1'b1;
        ifw.start   = 1'b1;
        @(negedge clk);
        ifw.start      = 1'b0;
        ifw.prod_valid = 1'b1;
        ifw.prod_data  = 16'h7FFF;
        @(negedge clk);
        ifw.prod_data  = 16'h0001;
        @(negedge clk);
        ifw.prod_valid = 1'b0;
        chk("wrap_y_valid", {15'd0, ifw.y_valid}, 16'd1);
        chk("wrap_y_data",  ifw.y_data,           16'h8000);
        chk("wrap_y_ovf",   {15'd0, ifw.y_ovf},   16'd1);
        @(negedge clk);
    endtask

    task automatic test_saturation();
        logic [15:0] v [4];
        v[0] = 16'h7000; v[1] = 16'h7000; v[2] = 16'hF000; v[3] = 16'h0000;
        ifs.y_ready = 1'b1;
        ifs.start   = 1'b1;
        @(negedge clk);
        ifs.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ifs.prod_valid = 1'b1;
            ifs.prod_data  = v[i];
            @(negedge clk);
        end
        ifs.prod_valid = 1'b0;
        chk("sat_y_valid", {15'd0, ifs.y_valid}, 16'd1);
        chk("sat_y_data",  ifs.y_data,           16'h6FFF);
        chk("sat_y_ovf",   {15'd0, ifs.y_ovf},   16'd1);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        ifa.y_ready = 1'b0;
        ifa.start   = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ifa.prod_valid = 1'b1;
            ifa.prod_data  = 16'(i + 1);
            @(negedge clk);
        end
        for (int c = 0; c < 5; c++) begin
            ifa.start      = (c % 2 == 0);
            ifa.prod_valid = 1'b1;
            ifa.prod_data  = 16'h0100;
            @(negedge clk);
            chk("bp_y_valid",    {15'd0, ifa.y_valid},    16'd1);
            chk("bp_y_data",     ifa.y_data,              16'd10);
            chk("bp_y_ovf",      {15'd0, ifa.y_ovf},      16'd0);
            chk("bp_prod_ready", {15'd0, ifa.prod_ready}, 16'd0);
        end
        ifa.start      = 1'b0;
        ifa.prod_valid = 1'b0;
        ifa.y_ready    = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {15'd0, ifa.y_valid}, 16'd0);
        chk("bp_release_busy",  {15'd0, ifa.busy},    16'd0);
        @(negedge clk);
        chk("bp_no_new_frame",  {15'd0, ifa.busy},    16'd0);
    endtask

    task automatic test_reset_mid_frame();
        ifa.y_ready = 1'b1;
        ifa.start   = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ifa.prod_valid = 1'b1;
            ifa.prod_data  = 16'h0050;
            @(negedge clk);
        end
        ifa.prod_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_prod_ready", {15'd0, ifa.prod_ready}, 16'd0);
        chk("mid_rst_busy",       {15'd0, ifa.busy},       16'd0);
        chk("mid_rst_y_valid",    {15'd0, ifa.y_valid},    16'd0);
        chk("mid_rst_y_data",     ifa.y_data,              16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_needs_start", {15'd0, ifa.busy}, 16'd0);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ifa.prod_valid = 1'b1;
            ifa.prod_data  = 16'h0001;
            @(negedge clk);
        end
        ifa.prod_valid = 1'b0;
        chk("mid_rst_y_valid2", {15'd0, ifa.y_valid}, 16'd1);
        chk("mid_rst_y_data2",  ifa.y_data,           16'd4);
        chk("mid_rst_y_ovf2",   {15'd0, ifa.y_ovf},   16'd0);
        @(negedge clk);
    endtask

    initial begin
        ifa.start = 1'b0; ifa.prod_valid = 1'b0; ifa.prod_data = '0; ifa.y_ready = 1'b1;
        ifw.start = 1'b0; ifw.prod_valid = 1'b0; ifw.prod_data = '0; ifw.y_ready = 1'b1;
        ifs.start = 1'b0; ifs.prod_valid = 1'b0; ifs.prod_data = '0; ifs.y_ready = 1'b1;
        test_reset();
        test_basic_sum();
        test_signed_stalls();
        test_wrap();
        test_saturation();
        test_backpressure();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fir_accum_seq.md
# fir_accum_seq

Sequencer that time-multiplexes a single 16-bit ripple-carry adder to accumulate one FIR output sample from a frame of NTAPS tap products. It sits between the tap-multiplier stage and the filter output register, accepting products on a valid/ready stream. It emits one signed 16-bit sum per frame, with an overflow flag and optional saturation.

## Interface
- NTAPS, 8, products per output sample; legal range 2..256.
- SATURATE, 0, 0 = wrap modulo 2^16; 1 = clamp to 16'h7FFF / 16'h8000 on signed overflow.

- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a new frame; honoured only in IDLE.
- prod_valid  input  1  prod_data is valid.
- prod_data  input  16  signed two's-complement tap product.
- prod_ready  output  1  block accepts a product this cycle.
- busy  output  1  high in every state except IDLE.
- y_valid  output  1  y_data and y_ovf are valid.
- y_ready  input  1  downstream accepts the result.
- y_data  output  16  signed accumulated sum.
- y_ovf  output  1  sticky: at least one signed overflow occurred during the frame.

## Operation
- **FSM states:** IDLE, ACC, OUT.
- **IDLE:** prod_ready=0, y_valid=0.
  - start=1 → ACC next cycle.
  - On that transition: acc←0, cnt←0, ovf←0.
- **ACC:** prod_ready=1.
  - Each handshake (prod_valid & prod_ready): acc ← rca(acc, prod_data, ci=0).s and cnt ← cnt+1.
  - Per-add overflow: ov = (acc[15]==prod_data[15]) & (s[15]!=acc[15]); ovf ← ovf | ov.
  - If SATURATE=1 and ov=1: acc ← acc[15] ? 16'h8000 : 16'h7FFF.
  - Handshake with cnt==NTAPS-1 → OUT next cycle.
  - Cycles without a handshake hold all state.
- **OUT:** prod_ready=0, y_valid=1, y_data=acc, y_ovf=ovf.
  - Outputs are stable until y_ready=1.
  - y_valid & y_ready → IDLE next cycle.
- start in ACC or OUT is ignored. It is not queued.
- The rca carry-out is unused. Width stays 16 bits; there is no internal growth.
- cnt width is $clog2(NTAPS), minimum 1.

## Timing
- Reset values: state=IDLE, acc=0, cnt=0, ovf=0, prod_ready=0, busy=0, y_valid=0, y_data=0, y_ovf=0.
- rst asserted mid-frame: the block enters IDLE immediately and the partial sum is discarded. The first frame after rst deasserts needs a fresh start.
- start sampled at edge N: prod_ready=1 from cycle N+1. The first product can be accepted at edge N+1.
- Latency: y_valid rises the cycle after the edge that accepts the last product.
- Minimum frame period is NTAPS+2 cycles (start, NTAPS accepts, OUT with y_ready=1).
- prod_ready and y_valid are registered state decodes with no combinational path from any input.
- The adder path (acc → rca → acc) is a single-cycle combinational ripple of 16 stages and sets the clock-period budget.
- y_ready held low: y_valid, y_data and y_ovf do not change. prod_valid is ignored.

## Structure
- Shared package fir_pkg:
  - state enum {IDLE, ACC, OUT}.
  - localparams DATA_W=16, SAT_MAX=16'h7FFF, SAT_MIN=16'h8000.
- One sub-module: instantiate the existing 16-bit `rca` adder once as `rca_inst`, with a=acc, b=prod_data, ci=1'b0.
- Do not infer a `+` operator.
- Overflow and saturation logic are inline muxing after the adder.

## Test plan
- **Basic sum:** NTAPS=4, SATURATE=0. Pulse start, feed 1, 2, 3, 4 back-to-back with y_ready=1 → y_valid one cycle after the 4th accept; y_data=10, y_ovf=0; IDLE the following cycle.
- **Signed mix with stalls:** NTAPS=4. Feed 16'hFFFF, 5, 16'hFFFE, 1 with prod_valid low for 2 cycles between items → y_data=3, y_ovf=0; cnt and acc hold during the gaps.
- **Wrap overflow:** NTAPS=2, SATURATE=0. Feed 16'h7FFF, 1 → y_data=16'h8000, y_ovf=1.
- **Saturation:** NTAPS=4, SATURATE=1. Feed 16'h7000, 16'h7000, 16'hF000, 0 → sat at 2nd add to 16'h7FFF, then y_data=16'h6FFF, y_ovf=1.
- **Backpressure and ignored start:** hold y_ready=0 for 5 cycles in OUT while pulsing start and prod_valid → y_valid and y_data stable, prod_ready=0, no new frame; y_ready=1 → IDLE.
- **Reset mid-frame:** after 2 of 4 products, assert rst for 1 cycle → all outputs 0 immediately. A new start with 1, 1, 1, 1 → y_data=4, with no residue from the aborted frame.
